// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl: packs 64-bit plaintext beats into 512-bit blocks for
// chacha_core, drives its init/next handshake with an auto-incrementing block
// counter, and unpacks the 512-bit result back into 64-bit ciphertext beats.
// Optional WAIT-state watchdog: define CHACHA_STREAM_TIMEOUT_EN.
module chacha_stream_ctrl #(
  parameter logic [63:0] CTR_INIT       = 64'd0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [63:0]  iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_last,
  output logic         done,
  output logic         ctr_wrap,
  output logic         err,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic [63:0]  core_ctr,
  output logic [63:0]  core_iv,
  output logic [511:0] core_data_in,
  input  logic         core_ready,
  input  logic         core_data_out_valid,
  input  logic [511:0] core_data_out
);

  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, DRAIN} state_t;

  state_t       state_q, state_d;
  logic         first_q;     // next issue is the message's first block
  logic         last_blk_q;  // block being processed ends the message
  logic [2:0]   wr_idx_q;    // next plaintext word slot
  logic [2:0]   rd_idx_q;    // next ciphertext word to emit
  logic [2:0]   last_idx_q;  // index of the last valid word (nbeats-1)
  logic [511:0] obuf_q;
  logic         in_fire, out_fire, fill_end, drain_end, timeout;
  logic [8:0]   wr_base, rd_base;

  // Word 0 lives in the MSBs, so slot k starts at bit 64*(7-k).
  assign wr_base   = {3'd7 - wr_idx_q, 6'd0};
  assign rd_base   = {3'd7 - rd_idx_q, 6'd0};
  assign out_data  = obuf_q[rd_base +: 64];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign fill_end  = in_fire & (in_last | (wr_idx_q == 3'd7));
  assign drain_end = out_fire & (rd_idx_q == last_idx_q);

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || wr_idx_q == 3'd7)) state_d = ISSUE;
      end
      ISSUE: if (core_ready) begin
        core_init = first_q;
        core_next = !first_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (core_data_out_valid) state_d = DRAIN;
        else if (timeout)        state_d = IDLE;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = last_blk_q && (rd_idx_q == last_idx_q);
        if (out_ready && rd_idx_q == last_idx_q) state_d = last_blk_q ? IDLE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath: key/iv/counter latching, block packing, result capture, pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q      <= 1'b0;
      last_blk_q   <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      last_idx_q   <= '0;
      core_key     <= '0;
      core_iv      <= '0;
      core_ctr     <= '0;
      core_data_in <= '0;
      // NOTE: the 512-bit buffer is plain flops, not a RAM, so it resets like the rest and out_data reads 0.
      obuf_q       <= '0;
      done         <= 1'b0;
      ctr_wrap     <= 1'b0;
    end else begin
      done     <= 1'b0;
      ctr_wrap <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          core_key     <= key;
          core_iv      <= iv;
          core_ctr     <= CTR_INIT;
          first_q      <= 1'b1;
          wr_idx_q     <= '0;
          core_data_in <= '0;
        end
        FILL: if (in_fire) begin
          core_data_in[wr_base +: 64] <= in_data;
          wr_idx_q <= fill_end ? 3'd0 : wr_idx_q + 3'd1;
          if (fill_end) begin
            last_idx_q <= wr_idx_q;
            last_blk_q <= in_last;
          end
        end
        ISSUE: if (core_ready) first_q <= 1'b0;
        WAIT: if (core_data_out_valid) begin
          // Result is a single-cycle pulse: capture it on the cycle it appears.
          obuf_q   <= core_data_out;
          rd_idx_q <= '0;
        end
        DRAIN: if (out_fire) begin
          rd_idx_q <= rd_idx_q + 3'd1;
          if (drain_end) begin
            if (last_blk_q) begin
              done <= 1'b1;
            end else begin
              core_ctr     <= core_ctr + 64'd1;
              ctr_wrap     <= &core_ctr;
              core_data_in <= '0;  // unfilled words of the next block read 0
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CHACHA_STREAM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q;

  assign timeout = (state_q == WAIT) && !core_data_out_valid &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent in WAIT, flags err when the limit expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      err        <= 1'b0;
    end else begin
      err        <= timeout;
      wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl: two instances (CTR_INIT = 0 and all-ones),
// each with a stand-in chacha_core that answers one cycle after a strobe.
// Expected ciphertext comes from a message-level model: beat i belongs to
// block i/8, word i%8, and uses counter CTR_INIT + i/8 (mod 2^64).
module tb_chacha_stream_ctrl;
  localparam logic [63:0]  CTR0    = 64'd0;
  localparam logic [63:0]  CTR1    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [255:0] KEY_PAT = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]   start, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [1:0]   done, ctr_wrap, err, core_init, core_next, core_ready, core_data_out_valid;
  logic [255:0] key [2];
  logic [255:0] core_key [2];
  logic [63:0]  iv [2];
  logic [63:0]  in_data [2];
  logic [63:0]  out_data [2];
  logic [63:0]  core_ctr [2];
  logic [63:0]  core_iv [2];
  logic [511:0] core_data_in [2];
  logic [511:0] core_data_out [2];

  logic [1:0]   core_hold, ready_rand;
  bit           ev_init [2][16];
  logic [63:0]  ev_ctr [2][16];
  int           ev_n [2];
  int           strobe_cyc [2];
  int           done_cnt [2];
  int           wrap_cnt [2];
  int           err_cnt [2];
  int           cyc;
  logic [63:0]  pt [32];
  logic [63:0]  exp_ct [32];
  int           n_checks, n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Keystream word w of a block; the core stand-in and the model share it.
  function automatic logic [63:0] ks(input logic [255:0] k, input logic [63:0] v,
                                     input logic [63:0] c, input int w);
    logic [63:0] kw;
    kw = k[255 - 64 * (w % 4) -: 64];
    return kw ^ (c * 64'h9E37_79B9_7F4A_7C15) ^ {v[31:0], v[63:32]} ^
           (64'(w + 1) << 56) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [511:0] core_fn(input logic [255:0] k, input logic [63:0] v,
                                           input logic [63:0] c, input logic [511:0] d);
    logic [511:0] r;
    for (int w = 0; w < 8; w++) r[511 - 64 * w -: 64] = d[511 - 64 * w -: 64] ^ ks(k, v, c, w);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    chacha_stream_ctrl #(.CTR_INIT(g == 0 ? CTR0 : CTR1), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start[g]), .key(key[g]), .iv(iv[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]), .in_last(in_last[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .out_last(out_last[g]), .done(done[g]), .ctr_wrap(ctr_wrap[g]), .err(err[g]),
      .core_init(core_init[g]), .core_next(core_next[g]), .core_key(core_key[g]),
      .core_ctr(core_ctr[g]), .core_iv(core_iv[g]), .core_data_in(core_data_in[g]),
      .core_ready(core_ready[g]), .core_data_out_valid(core_data_out_valid[g]),
      .core_data_out(core_data_out[g]));

    // Core stand-in: records each strobe, answers with a one-cycle valid pulse.
    initial begin
      logic         pending;
      logic [511:0] result;
      pending = 1'b0;
      core_ready[g] = 1'b0;
      core_data_out_valid[g] = 1'b0;
      core_data_out[g] = '0;
      forever begin
        @(posedge clk);
        #1 core_ready[g] = ready_rand[g] ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        core_data_out_valid[g] = 1'b0;
        if (!reset_n) begin
          pending = 1'b0;
        end else begin
          if (pending) begin
            core_data_out_valid[g] = 1'b1;
            core_data_out[g] = result;
            pending = 1'b0;
          end
          if (core_init[g] || core_next[g]) begin
            check("strobe_needs_ready", 64'(core_ready[g]), 64'd1);
            check("single_strobe", 64'(core_init[g] & core_next[g]), 64'd0);
            if (ev_n[g] < 16) begin
              ev_init[g][ev_n[g]] = core_init[g];
              ev_ctr[g][ev_n[g]]  = core_ctr[g];
            end
            ev_n[g]++;
            strobe_cyc[g] = cyc;
            if (!core_hold[g]) begin
              pending = 1'b1;
              result  = core_fn(core_key[g], core_iv[g], core_ctr[g], core_data_in[g]);
            end
          end
        end
      end
    end
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        done_cnt[g] += int'(done[g]);
        wrap_cnt[g] += int'(ctr_wrap[g]);
        err_cnt[g]  += int'(err[g]);
      end
    end
  end

  task automatic send_beats(input int u, input int n);
    int waited;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid[u] = 1'b1;
      in_data[u]  = pt[i];
      in_last[u]  = (i == n - 1);
      waited = 0;
      while (!in_ready[u] && waited < 300) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready[u]) begin
        timeout_fail("in_accept");
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_last[u]  = 1'b0;
  endtask

  // mode 0: always ready; 1: 5-cycle stall after two beats; 2: random ready.
  task automatic collect(input int u, input int n, input int mode);
    int          got = 0, budget = 0, stall = 0;
    bit          fin = 0, prev_stalled = 0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    while (!fin && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (prev_stalled) begin
        check("hold_valid", 64'(out_valid[u]), 64'd1);
        check("hold_data", out_data[u], prev_data);
        check("hold_last", 64'(out_last[u]), 64'(prev_last));
        check("no_fill_in_drain", 64'(in_ready[u]), 64'd0);
      end
      if (mode == 1 && got == 2 && stall < 5 && out_valid[u]) begin
        out_ready[u] = 1'b0;
        stall++;
      end else if (mode == 2) begin
        out_ready[u] = 1'($urandom_range(0, 1));
      end else begin
        out_ready[u] = 1'b1;
      end
      prev_stalled = out_valid[u] && !out_ready[u];
      prev_data    = out_data[u];
      prev_last    = out_last[u];
      if (out_valid[u] && out_ready[u]) begin
        check("out_data", out_data[u], exp_ct[got]);
        check("out_last", 64'(out_last[u]), 64'(got == n - 1));
        got++;
        if (got == n || out_last[u]) fin = 1;
      end
    end
    if (!fin) begin
      timeout_fail("out_beats");
    end else begin
      check("beat_count", 64'(got), 64'(n));
      @(negedge clk);
      check("done_pulse", 64'(done[u]), 64'd1);
      repeat (3) begin
        @(negedge clk);
        check("no_extra_beats", 64'(out_valid[u]), 64'd0);
      end
      check("done_one_cycle", 64'(done[u]), 64'd0);
    end
    out_ready[u] = 1'b0;
  endtask

  task automatic do_start(input int u, input logic [255:0] k, input logic [63:0] v);
    @(negedge clk);
    key[u] = k;
    iv[u] = v;
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  task automatic run_msg(input int u, input int n, input int mode, input bit zero_pt,
                         input logic [255:0] k, input logic [63:0] v,
                         input int exp_blocks, input int exp_wraps);
    logic [63:0] base;
    int          done0, wrap0;
    base = (u == 0) ? CTR0 : CTR1;
    for (int i = 0; i < n; i++) begin
      pt[i]     = zero_pt ? 64'd0 : {$urandom, $urandom};
      exp_ct[i] = pt[i] ^ ks(k, v, base + 64'(i / 8), i % 8);
    end
    ev_n[u] = 0;
    done0 = done_cnt[u];
    wrap0 = wrap_cnt[u];
    do_start(u, k, v);
    fork
      send_beats(u, n);
      collect(u, n, mode);
    join
    check("block_count", 64'(ev_n[u]), 64'(exp_blocks));
    for (int b = 0; b < exp_blocks && b < ev_n[u] && b < 16; b++) begin
      check("strobe_is_init", 64'(ev_init[u][b]), 64'(b == 0));
      check("strobe_ctr", ev_ctr[u][b], base + 64'(b));
    end
    check("done_count", 64'(done_cnt[u] - done0), 64'd1);
    check("wrap_count", 64'(wrap_cnt[u] - wrap0), 64'(exp_wraps));
  endtask

  task automatic check_all_zero(input int u);
    check("rst_in_ready", 64'(in_ready[u]), 64'd0);
    check("rst_out_valid", 64'(out_valid[u]), 64'd0);
    check("rst_out_last", 64'(out_last[u]), 64'd0);
    check("rst_out_data", out_data[u], 64'd0);
    check("rst_done", 64'(done[u]), 64'd0);
    check("rst_ctr_wrap", 64'(ctr_wrap[u]), 64'd0);
    check("rst_err", 64'(err[u]), 64'd0);
    check("rst_strobes", 64'({core_init[u], core_next[u]}), 64'd0);
    check("rst_core_data_in", 64'(|core_data_in[u]), 64'd0);
    check("rst_core_key", 64'(|core_key[u]), 64'd0);
    check("rst_core_iv", core_iv[u], 64'd0);
    check("rst_core_ctr", core_ctr[u], 64'd0);
  endtask

  typedef struct {
    int           u;
    int           n;
    int           mode;
    bit           zero_pt;
    logic [255:0] k;
    logic [63:0]  v;
    int           exp_blocks;
    int           exp_wraps;
  } vec_t;

  vec_t vecs [6];

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset_n = 1'b0;
    start = '0; in_valid = '0; in_last = '0; out_ready = '0;
    core_hold = '0; ready_rand = '0;
    for (int g = 0; g < 2; g++) begin
      key[g] = '0; iv[g] = '0; in_data[g] = '0;
      ev_n[g] = 0; done_cnt[g] = 0; wrap_cnt[g] = 0; err_cnt[g] = 0; strobe_cyc[g] = 0;
    end

    vecs[0] = '{0,  8, 0, 1, KEY_PAT,  64'd0,                  1, 0};
    vecs[1] = '{0, 13, 0, 0, KEY_PAT,  64'h0000_0000_0000_0001, 2, 0};
    vecs[2] = '{0, 12, 1, 0, ~KEY_PAT, 64'hDEAD_BEEF_0BAD_F00D, 2, 0};
    vecs[3] = '{0,  1, 0, 0, KEY_PAT,  64'h1234_5678_9ABC_DEF0, 1, 0};
    vecs[4] = '{1, 13, 0, 0, KEY_PAT,  64'h0F0F_0F0F_0F0F_0F0F, 2, 1};
    vecs[5] = '{0, 24, 2, 0, ~KEY_PAT, 64'h5555_AAAA_5555_AAAA, 3, 0};

    repeat (3) @(negedge clk);
    check_all_zero(0);
    check_all_zero(1);
    reset_n = 1'b1;

    // IDLE never accepts beats.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0] = 64'hFFFF_0000_FFFF_0000;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready[0]), 64'd0);
    end
    in_valid[0] = 1'b0;

    for (int t = 0; t < 6; t++)
      run_msg(vecs[t].u, vecs[t].n, vecs[t].mode, vecs[t].zero_pt, vecs[t].k, vecs[t].v,
              vecs[t].exp_blocks, vecs[t].exp_wraps);

    // Randomized messages with random core_ready and out_ready.
    for (int t = 0; t < 8; t++) begin
      int           u, n, blocks;
      logic [255:0] k;
      u = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 24));
      blocks = (n + 7) / 8;
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ready_rand[u] = 1'b1;
      run_msg(u, n, 2, 1'b0, k, {$urandom, $urandom}, blocks, (u == 1 && blocks > 1) ? 1 : 0);
      ready_rand[u] = 1'b0;
    end

    // Reset while WAIT is stuck on a silent core, then a normal message.
    core_hold[0] = 1'b1;
    for (int i = 0; i < 8; i++) pt[i] = {$urandom, $urandom} | 64'd1;
    do_start(0, ~KEY_PAT, 64'hCAFE_F00D_CAFE_F00D);
    send_beats(0, 8);
    repeat (4) begin
      @(negedge clk);
      check("wait_no_output", 64'(out_valid[0]), 64'd0);
    end
    check("wait_ctr_loaded", core_ctr[0], CTR0);
    check("wait_block_packed", core_data_in[0][511:448], pt[0]);
    #2 reset_n = 1'b0;
    #1 check_all_zero(0);
    @(negedge clk);
    reset_n = 1'b1;
    core_hold[0] = 1'b0;
    run_msg(0, 10, 0, 1'b0, KEY_PAT, 64'h0000_0000_0000_0042, 2, 0);

`ifdef CHACHA_STREAM_TIMEOUT_EN
    begin : timeout_test
      int budget;
      core_hold[0] = 1'b1;
      for (int i = 0; i < 3; i++) pt[i] = {$urandom, $urandom};
      do_start(0, KEY_PAT, 64'd7);
      send_beats(0, 3);
      budget = 0;
      while (!err[0] && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      if (!err[0]) timeout_fail("err_pulse");
      else check("err_latency", 64'(cyc - strobe_cyc[0]), 64'd17);
      @(negedge clk);
      check("err_one_cycle", 64'(err[0]), 64'd0);
      check("timeout_to_idle", 64'(in_ready[0]), 64'd0);
      core_hold[0] = 1'b0;
      run_msg(0, 5, 0, 1'b0, KEY_PAT, 64'd9, 1, 0);
    end
`else
    check("err_tied_low", 64'(err_cnt[0] + err_cnt[1]), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
